word_gen_op_seq: RTL and testbench
==================================

Name: word_gen_op_seq

Overview:
- Sequencer driving the shared op_state/op_en bus of a chain of character-range generators in the word generator.
- Walks the range chain through load, optional pipeline-fill, and per-word advance.
- Exposes a valid/read handshake for each generated word, counts words, and signals completion.
- Sits between the configuration front end (start pulse, word limit) and the downstream candidate consumer.

Parameters:
- WORD_CNT_MSB, 31, MSB of word counter and word limit.
- SETTLE_CYCLES, 1, idle cycles after each advance before the new word is presented (range outputs are registered).

Ports:
- OP_CLK  in  1  generation clock.
- rstb  in  1  synchronous active-high reset.
- start  in  1  one-cycle pulse: ranges configured, begin generation.
- word_limit  in  WORD_CNT_MSB+1  maximum words to emit; 0 = unlimited. Sampled on accepted start.
- all_carry  in  1  carry out of the most-significant range (whole chain about to wrap).
- op_state  out  3  state bus to all ranges.
- op_en  out  1  advance strobe to the range chain (carry_in of least-significant range).
- word_valid  out  1  current word on range outputs is stable.
- word_rd  in  1  consumer takes current word.
- word_cnt  out  WORD_CNT_MSB+1  words consumed since start.
- op_done  out  1  one-cycle completion pulse.
- busy  out  1  high in any state except READY.

Behaviour:
- Reset, synchronous on rstb:
  - State = READY.
  - op_en = 0, word_valid = 0, word_cnt = 0, op_done = 0, busy = 0.
  - Settle counter = 0, stored limit = 0.
  - Reset mid-generation aborts immediately; no op_done pulse.
- READY: op_state = READY. On start, latch word_limit, clear word_cnt, go to START. start in any other state is ignored.
- START: op_state = START for exactly 1 cycle; ranges fetch their first char. Next state is EXTRA_STAGE if the feature is enabled, otherwise SETTLE.
- EXTRA_STAGE: op_state = EXTRA_STAGE for exactly 1 cycle, then SETTLE.
- SETTLE:
  - op_state = NEXT_CHAR, op_en = 0, word_valid = 0.
  - Counter runs SETTLE_CYCLES cycles, then WORD.
- WORD:
  - op_state = NEXT_CHAR, word_valid = 1.
  - On word_rd, in the same cycle:
    - Assert op_en (combinational from word_rd & word_valid).
    - Increment word_cnt on the edge.
  - If all_carry was high in that cycle, or the incremented word_cnt equals a nonzero limit: go to DONE with op_en still asserted; the ranges wrap harmlessly.
  - Otherwise go to SETTLE.
  - word_rd while word_valid = 0 is ignored.
  - Throughput: one word per SETTLE_CYCLES+1 cycles.
- DONE:
  - op_state = READY, op_done = 1 for 1 cycle, busy = 0, then READY.
  - word_cnt holds its final value until the next accepted start.
- op_en is never asserted outside WORD.
- word_cnt wraps modulo 2^(WORD_CNT_MSB+1) only when unlimited; no saturation.
- all_carry is ignored outside WORD.
- If the chain is empty (all_carry high on the first word), exactly one word is emitted, then done.

Optional Feature:
- Macro: WORD_GEN_EXTRA_STAGE_EN.
- Defined: START→EXTRA_STAGE→SETTLE; first word_valid appears at start+3+SETTLE_CYCLES cycles.
- Undefined: EXTRA_STAGE is never entered; first word_valid appears at start+2+SETTLE_CYCLES cycles.
- Bus encoding is identical in both builds.

Decomposition:
- Shared package (word_gen.vh) holds:
  - OP_STATE_READY=0, OP_STATE_START=1, OP_STATE_EXTRA_STAGE=2, OP_STATE_NEXT_CHAR=3.
  - EXTRA_STAGE_REGISTER derived from the macro.
- Internal FSM encoding (READY, START, EXTRA_STAGE, SETTLE, WORD, DONE) is local.
- One natural sub-module: word_gen_op_cnt, a word counter with limit compare producing limit_hit.

Test Plan:
- Feature off, SETTLE_CYCLES=1, limit=0, start at cycle 0, all_carry high on the 4th word, word_rd held 1 → op_state 1 at cycle 1; word_valid at cycles 3,5,7,9; op_en at the same cycles; op_done at cycle 10; word_cnt=4.
- Feature on, same stimulus → op_state 1 then 2 at cycles 1,2; first word_valid at cycle 4; op_done at cycle 11.
- limit=3, all_carry=0, word_rd=1 → exactly 3 op_en pulses, word_cnt=3, one op_done pulse.
- word_rd toggled 1/0 every cycle, limit=5 → op_en only when word_valid & word_rd; word_cnt=5; no op_en in SETTLE.
- rstb asserted while in WORD after 2 words → next cycle op_state=0, word_valid=0, word_cnt=0, no op_done pulse.
- start pulsed while busy → ignored; word_limit change mid-run has no effect.

Source files
------------

// File: rtl/word_gen_op_seq_pkg.sv
// Shared constants for the word generator op_state/op_en bus.
// The op_state encoding is seen by every range in the chain, so it
// must not change between builds. Build option: WORD_GEN_EXTRA_STAGE_EN
// inserts a one-cycle EXTRA_STAGE after START for range pipeline fill.
package word_gen_op_seq_pkg;

  // Encoding driven onto the shared op_state bus
  localparam logic [2:0] OP_STATE_READY       = 3'd0;
  localparam logic [2:0] OP_STATE_START       = 3'd1;
  localparam logic [2:0] OP_STATE_EXTRA_STAGE = 3'd2;
  localparam logic [2:0] OP_STATE_NEXT_CHAR   = 3'd3;

`ifdef WORD_GEN_EXTRA_STAGE_EN
  localparam bit EXTRA_STAGE_REGISTER = 1'b1;
`else
  localparam bit EXTRA_STAGE_REGISTER = 1'b0;
`endif

  // Bits needed to count 0..n-1 (at least one bit)
  function automatic int settle_w(int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/word_gen_op_cnt.sv
// Word counter with limit compare. The limit is captured together with
// the counter clear on an accepted start; a zero limit means unlimited.
// limit_hit looks at the incremented value, so it flags the word that is
// being consumed in the current cycle as the last one.
module word_gen_op_cnt #(
  parameter int WORD_CNT_MSB = 31
) (
  input  logic                  OP_CLK,
  input  logic                  rstb,
  input  logic                  i_clr,
  input  logic [WORD_CNT_MSB:0] i_limit,
  input  logic                  i_inc,
  output logic [WORD_CNT_MSB:0] o_cnt,
  output logic                  o_limit_hit
);

  localparam int                  CW  = WORD_CNT_MSB + 1;
  localparam logic [WORD_CNT_MSB:0] ONE = CW'(1);

  logic [WORD_CNT_MSB:0] r_cnt;
  logic [WORD_CNT_MSB:0] r_limit;
  logic [WORD_CNT_MSB:0] w_cnt_inc;

  assign w_cnt_inc   = r_cnt + ONE;
  assign o_limit_hit = (r_limit != '0) && (w_cnt_inc == r_limit);
  assign o_cnt       = r_cnt;

  // Clear and capture limit on start, otherwise count consumed words (wraps freely)
  always_ff @(posedge OP_CLK) begin
    if (rstb) begin
      r_cnt   <= '0;
      r_limit <= '0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_limit <= i_limit;
    end else if (i_inc) begin
      r_cnt   <= w_cnt_inc;
    end
  end

endmodule

// File: rtl/word_gen_op_seq.sv
// Sequencer for the character-range chain: load (START), optional
// pipeline fill (EXTRA_STAGE, enabled by WORD_GEN_EXTRA_STAGE_EN),
// then alternate SETTLE / WORD until the chain wraps or the word limit
// is reached. op_en is the carry_in of the least-significant range and
// fires only when the consumer takes a valid word.
module word_gen_op_seq
  import word_gen_op_seq_pkg::*;
#(
  parameter int WORD_CNT_MSB  = 31,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic                  OP_CLK,
  input  logic                  rstb,
  input  logic                  start,
  input  logic [WORD_CNT_MSB:0] word_limit,
  input  logic                  all_carry,
  output logic [2:0]            op_state,
  output logic                  op_en,
  output logic                  word_valid,
  input  logic                  word_rd,
  output logic [WORD_CNT_MSB:0] word_cnt,
  output logic                  op_done,
  output logic                  busy
);

  // Internal FSM encoding
  localparam logic [2:0] S_READY  = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_EXTRA  = 3'd2;
  localparam logic [2:0] S_SETTLE = 3'd3;
  localparam logic [2:0] S_WORD   = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

  localparam int              SW          = settle_w(SETTLE_CYCLES);
  localparam logic [SW-1:0]   SETTLE_LAST = SW'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
  localparam logic [SW-1:0]   SETTLE_ONE  = SW'(1);
  // With no settle time the next word is presented straight away
  localparam logic [2:0]      S_AFTER     = (SETTLE_CYCLES == 0) ? S_WORD : S_SETTLE;

  logic [2:0]    r_state;
  logic [2:0]    w_nxt;
  logic [SW-1:0] r_settle;
  logic          w_take;
  logic          w_limit_hit;

  assign word_valid = (r_state == S_WORD);
  assign w_take     = word_valid & word_rd;
  assign op_en      = w_take;
  assign op_done    = (r_state == S_DONE);
  assign busy       = (r_state != S_READY) && (r_state != S_DONE);

  word_gen_op_cnt #(.WORD_CNT_MSB(WORD_CNT_MSB)) u_cnt (
    .OP_CLK      (OP_CLK),
    .rstb        (rstb),
    .i_clr       ((r_state == S_READY) & start),
    .i_limit     (word_limit),
    .i_inc       (w_take),
    .o_cnt       (word_cnt),
    .o_limit_hit (w_limit_hit)
  );

  // Next-state: start only honoured in READY, all_carry only looked at in WORD
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      S_READY:  if (start) w_nxt = S_START;
      S_START:  w_nxt = EXTRA_STAGE_REGISTER ? S_EXTRA : S_AFTER;
      S_EXTRA:  w_nxt = S_AFTER;
      S_SETTLE: if (r_settle == SETTLE_LAST) w_nxt = S_WORD;
      S_WORD:   if (w_take) w_nxt = (all_carry || w_limit_hit) ? S_DONE : S_AFTER;
      S_DONE:   w_nxt = S_READY;
      default:  w_nxt = S_READY;
    endcase
  end

  // State register; reset aborts generation without a done pulse
  always_ff @(posedge OP_CLK) begin
    if (rstb) r_state <= S_READY;
    else      r_state <= w_nxt;
  end

  // Settle counter runs only inside SETTLE and is zero on entry
  always_ff @(posedge OP_CLK) begin
    if (rstb)                                                 r_settle <= '0;
    else if ((r_state == S_SETTLE) && (r_settle != SETTLE_LAST)) r_settle <= r_settle + SETTLE_ONE;
    else                                                      r_settle <= '0;
  end

  // Bus encoding seen by the ranges
  always_comb begin
    op_state = OP_STATE_READY;
    unique case (r_state)
      S_START:         op_state = OP_STATE_START;
      S_EXTRA:         op_state = OP_STATE_EXTRA_STAGE;
      S_SETTLE, S_WORD: op_state = OP_STATE_NEXT_CHAR;
      default:         op_state = OP_STATE_READY;
    endcase
  end

endmodule

// File: tb/tb_word_gen_op_seq.sv
// Bench for word_gen_op_seq. Expected per-cycle bus traces are built from
// the documented timing (first word at start+2+SETTLE_CYCLES, +1 with the
// extra stage; one word per SETTLE_CYCLES+1 cycles; done one cycle after
// the last word) and queued as stimulus is driven, then popped at the
// falling edge and compared.
`timescale 1ns/1ps
module tb_word_gen_op_seq;
  import word_gen_op_seq_pkg::*;

  localparam int WORD_CNT_MSB  = 31;
  localparam int SETTLE_CYCLES = 1;
  localparam int W             = WORD_CNT_MSB + 1;
  localparam int E             = EXTRA_STAGE_REGISTER ? 1 : 0;
  localparam int FIRST         = 2 + E + SETTLE_CYCLES;
  localparam int STEP          = SETTLE_CYCLES + 1;

  logic         OP_CLK = 1'b0;
  logic         rstb = 1'b1;
  logic         start = 1'b0;
  logic [W-1:0] word_limit = '0;
  logic         all_carry = 1'b0;
  logic         word_rd = 1'b0;
  logic [2:0]   op_state;
  logic         op_en, word_valid, op_done, busy;
  logic [W-1:0] word_cnt;

  typedef struct packed {
    logic [2:0]   st;
    logic         en;
    logic         vld;
    logic         done;
    logic         busy;
    logic [W-1:0] cnt;
  } obs_t;

  obs_t         exp_q[$];
  logic [W-1:0] cnt_q[$];
  int           n_vec = 0;
  int           n_err = 0;
  logic [W-1:0] prev_cnt = '0;

  word_gen_op_seq #(.WORD_CNT_MSB(WORD_CNT_MSB), .SETTLE_CYCLES(SETTLE_CYCLES)) dut (
    .OP_CLK     (OP_CLK),
    .rstb       (rstb),
    .start      (start),
    .word_limit (word_limit),
    .all_carry  (all_carry),
    .op_state   (op_state),
    .op_en      (op_en),
    .word_valid (word_valid),
    .word_rd    (word_rd),
    .word_cnt   (word_cnt),
    .op_done    (op_done),
    .busy       (busy)
  );

  always #5 OP_CLK = ~OP_CLK;

  task automatic next_cycle();
    @(posedge OP_CLK);
    #1;
  endtask

  function automatic obs_t observe();
    obs_t o;
    o = {op_state, op_en, word_valid, op_done, busy, word_cnt};
    return o;
  endfunction

  task automatic test_reset();
    obs_t a, e;
    rstb = 1'b1; start = 1'b1; word_rd = 1'b1; all_carry = 1'b1; word_limit = W'(7);
    repeat (3) next_cycle();
    e = '0;
    @(negedge OP_CLK);
    a = observe();
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL reset_held: got %h want %h", a, e);
    end
    @(posedge OP_CLK); #1;
    rstb = 1'b0; start = 1'b0; word_rd = 1'b0; all_carry = 1'b0; word_limit = '0;
    @(negedge OP_CLK);
    a = observe();
    n_vec++;
    if (a !== e) begin
      n_err++;
      $display("FAIL reset_release: got %h want %h", a, e);
    end
    next_cycle();
  endtask

  // carry_mode: 0 never, 1 on last word plus ignored pulses in START/SETTLE, 2 always high.
  // noise: start pulses and word_limit changes while busy and in DONE.
  task automatic run_trace(input string name, input logic [W-1:0] limit, input int nwords,
                           input int carry_mode, input bit noise);
    int last_w, done_c, en_seen, done_seen, consumed;
    bit is_word;
    obs_t e, a;
    last_w    = FIRST + (nwords - 1) * STEP;
    done_c    = last_w + 1;
    en_seen   = 0;
    done_seen = 0;
    for (int c = 0; c <= done_c + 1; c++) begin
      start   = (c == 0) || (noise && (c == 2 || c == last_w || c == done_c));
      if (c == 0)     word_limit = limit;
      else if (noise) word_limit = W'(1);
      word_rd = 1'b1;
      case (carry_mode)
        1:       all_carry = (c == 1) || (c == FIRST - 1) || (c == last_w);
        2:       all_carry = 1'b1;
        default: all_carry = 1'b0;
      endcase
      is_word  = (c >= FIRST) && (c <= last_w) && (((c - FIRST) % STEP) == 0);
      consumed = (c <= FIRST) ? 0 : ((c - 1 - FIRST) / STEP + 1);
      if (consumed > nwords) consumed = nwords;
      if (c == 0)                e.st = OP_STATE_READY;
      else if (c == 1)           e.st = OP_STATE_START;
      else if (E == 1 && c == 2) e.st = OP_STATE_EXTRA_STAGE;
      else if (c < done_c)       e.st = OP_STATE_NEXT_CHAR;
      else                       e.st = OP_STATE_READY;
      e.en   = is_word;
      e.vld  = is_word;
      e.done = (c == done_c);
      e.busy = (c >= 1) && (c < done_c);
      e.cnt  = (c == 0) ? prev_cnt : W'(consumed);
      exp_q.push_back(e);
      @(negedge OP_CLK);
      a = observe();
      e = exp_q.pop_front();
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL %s cycle %0d: got st=%0d en=%b vld=%b done=%b busy=%b cnt=%0d want st=%0d en=%b vld=%b done=%b busy=%b cnt=%0d",
                 name, c, a.st, a.en, a.vld, a.done, a.busy, a.cnt, e.st, e.en, e.vld, e.done, e.busy, e.cnt);
      end
      en_seen   += int'(a.en);
      done_seen += int'(a.done);
      next_cycle();
    end
    start = 1'b0; all_carry = 1'b0;
    n_vec++;
    if (en_seen != nwords) begin
      n_err++;
      $display("FAIL %s_en_pulses: got %0d want %0d", name, en_seen, nwords);
    end
    n_vec++;
    if (done_seen != 1) begin
      n_err++;
      $display("FAIL %s_done_pulses: got %0d want 1", name, done_seen);
    end
    prev_cnt = W'(nwords);
  endtask

  task automatic test_chain_wrap();
    run_trace("chain_wrap", '0, 4, 1, 1'b0);
  endtask

  task automatic test_limit();
    run_trace("limit3", W'(3), 3, 0, 1'b0);
    run_trace("limit1", W'(1), 1, 0, 1'b0);
  endtask

  task automatic test_empty_chain();
    run_trace("empty_chain", '0, 1, 2, 1'b0);
  endtask

  task automatic test_busy_start();
    run_trace("busy_start", W'(2), 2, 0, 1'b1);
  endtask

  task automatic test_toggle_rd();
    int hs, en_n, dones, c;
    bit fin;
    logic [W-1:0] ec;
    hs = 0; en_n = 0; dones = 0; c = 0; fin = 1'b0;
    word_limit = W'(5); all_carry = 1'b0;
    while (!fin && c < 200) begin
      start   = (c == 0);
      word_rd = ((c % 2) == 0);
      @(negedge OP_CLK);
      if (cnt_q.size() > 0) begin
        ec = cnt_q.pop_front();
        n_vec++;
        if (word_cnt !== ec) begin
          n_err++;
          $display("FAIL toggle_cnt cycle %0d: got %0d want %0d", c, word_cnt, ec);
        end
      end
      n_vec++;
      if (op_en !== (word_valid & word_rd)) begin
        n_err++;
        $display("FAIL toggle_en cycle %0d: got %b want %b", c, op_en, word_valid & word_rd);
      end
      en_n += int'(op_en === 1'b1);
      if (word_valid === 1'b1 && word_rd) begin
        hs++;
        cnt_q.push_back(W'(hs));
      end
      if (op_done === 1'b1) begin
        dones++;
        fin = 1'b1;
      end
      next_cycle();
      c++;
    end
    start = 1'b0;
    n_vec++;
    if (!fin) begin
      n_err++;
      $display("FAIL toggle_timeout: got no op_done want op_done within 200 cycles");
    end
    n_vec++;
    if (en_n != 5 || hs != 5) begin
      n_err++;
      $display("FAIL toggle_words: got en=%0d hs=%0d want 5", en_n, hs);
    end
    @(negedge OP_CLK);
    n_vec++;
    if (word_cnt !== W'(5) || op_done !== 1'b0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL toggle_final: got cnt=%0d done=%b busy=%b want cnt=5 done=0 busy=0", word_cnt, op_done, busy);
    end
    next_cycle();
    cnt_q.delete();
    prev_cnt = W'(5);
  endtask

  task automatic test_reset_mid();
    int third;
    third = FIRST + 2 * STEP;
    word_limit = '0; all_carry = 1'b0; word_rd = 1'b1;
    start = 1'b1;
    next_cycle();
    start = 1'b0;
    repeat (third - 1) next_cycle();
    @(negedge OP_CLK);
    n_vec++;
    if (word_valid !== 1'b1 || word_cnt !== W'(2)) begin
      n_err++;
      $display("FAIL rst_mid_pre: got vld=%b cnt=%0d want vld=1 cnt=2", word_valid, word_cnt);
    end
    rstb = 1'b1;
    @(posedge OP_CLK); #1;
    rstb = 1'b0;
    @(negedge OP_CLK);
    n_vec++;
    if (op_state !== OP_STATE_READY || word_valid !== 1'b0 || word_cnt !== '0 ||
        op_done !== 1'b0 || busy !== 1'b0 || op_en !== 1'b0) begin
      n_err++;
      $display("FAIL rst_mid_post: got st=%0d vld=%b cnt=%0d done=%b busy=%b en=%b want st=0 vld=0 cnt=0 done=0 busy=0 en=0",
               op_state, word_valid, word_cnt, op_done, busy, op_en);
    end
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      @(negedge OP_CLK);
      n_vec++;
      if (op_done !== 1'b0 || op_state !== OP_STATE_READY) begin
        n_err++;
        $display("FAIL rst_mid_idle %0d: got done=%b st=%0d want done=0 st=0", k, op_done, op_state);
      end
    end
    next_cycle();
    prev_cnt = '0;
  endtask

  initial begin
    test_reset();
    test_chain_wrap();
    test_limit();
    test_empty_chain();
    test_toggle_rd();
    test_busy_start();
    test_reset_mid();
    run_trace("after_reset", W'(4), 4, 0, 1'b0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
